// File: rtl/mutex_merge_rr.sv
// Merges N_CH upstream drive/free channels into a single downstream drive/free channel.
// Payloads are latched on drive and only one token is in flight downstream at a time.
//
// state   | meaning
// IDLE    | no token downstream; grant the next pending channel if any
// WAIT    | token presented downstream; waiting for i_freeNext
module mutex_merge_rr #(
  parameter int N_CH      = 5,
  parameter int DATA_W    = 5,
  parameter int PRIO_MODE = 0,
  localparam int IDX_W    = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        i_drive,
  input  logic [N_CH*DATA_W-1:0] i_data,
  output logic [N_CH-1:0]        o_free,
  output logic                   o_driveNext,
  output logic [DATA_W-1:0]      o_data,
  output logic [IDX_W-1:0]       o_chan,
  input  logic                   i_freeNext,
  output logic                   o_busy,
  output logic                   o_err
);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;
  localparam int   SCAN_W  = IDX_W + 1;

  logic              state;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   capture;
  logic [N_CH-1:0]   clr;
  logic [DATA_W-1:0] data_buf [N_CH];
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  chan_inc;
  logic [SCAN_W-1:0] scan;
  logic              grant_vld;
  logic              done;

  assign capture  = i_drive & ~pending;
  assign done     = (state == ST_WAIT) && i_freeNext;
  assign clr      = done ? (N_CH'(1) << o_chan) : '0;
  assign chan_inc = (o_chan == IDX_W'(N_CH - 1)) ? '0 : o_chan + IDX_W'(1);
  assign o_busy   = (state == ST_WAIT);

  // Scan downwards so the last hit is the one closest to the scan start.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan      = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (PRIO_MODE == 1) scan = SCAN_W'(i);
      else                scan = {1'b0, rr_ptr} + SCAN_W'(i);
      if (scan >= SCAN_W'(N_CH)) scan = scan - SCAN_W'(N_CH);
      if (pending[scan[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = scan[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      rr_ptr      <= '0;
      o_free      <= '0;
      o_driveNext <= 1'b0;
      o_data      <= '0;
      o_chan      <= '0;
      o_err       <= 1'b0;
      for (int k = 0; k < N_CH; k++) data_buf[k] <= '0;
    end else begin
      pending     <= (pending & ~clr) | capture;
      o_free      <= clr;
      o_driveNext <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        if (capture[k]) data_buf[k] <= i_data[k*DATA_W +: DATA_W];
      end
      // A drive onto a still-pending channel is dropped, even on the edge that frees it.
      if ((|(i_drive & pending)) || (i_freeNext && state == ST_IDLE)) o_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            o_data      <= data_buf[grant];
            o_chan      <= grant;
            o_driveNext <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        default: begin
          if (i_freeNext) begin
            rr_ptr <= chan_inc;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mutex_merge_rr.sv
// Scoreboard bench for mutex_merge_rr: one round-robin and one fixed-priority instance.
module tb_mutex_merge_rr;
  logic clk;
  logic rst;

  logic [4:0]  drive_r, free_r, odata_r;
  logic [24:0] data_r;
  logic        fn_auto_r, fn_man_r, auto_r, dn_r, busy_r, err_r;
  logic [2:0]  chan_r;

  logic [4:0]  drive_f, free_f, odata_f;
  logic [24:0] data_f;
  logic        fn_auto_f, dn_f, busy_f, err_f;
  logic [2:0]  chan_f;

  logic [7:0]  q_r[$], q_f[$];
  logic [4:0]  fq_r[$], fq_f[$];
  logic [7:0]  e_r, e_f;
  int          n_chk, n_pass;

  mutex_merge_rr #(.N_CH(5), .DATA_W(5), .PRIO_MODE(0)) dut_r (
    .clk(clk), .rst(rst), .i_drive(drive_r), .i_data(data_r), .o_free(free_r),
    .o_driveNext(dn_r), .o_data(odata_r), .o_chan(chan_r),
    .i_freeNext(fn_auto_r | fn_man_r), .o_busy(busy_r), .o_err(err_r)
  );

  mutex_merge_rr #(.N_CH(5), .DATA_W(5), .PRIO_MODE(1)) dut_f (
    .clk(clk), .rst(rst), .i_drive(drive_f), .i_data(data_f), .o_free(free_f),
    .o_driveNext(dn_f), .o_data(odata_f), .o_chan(chan_f),
    .i_freeNext(fn_auto_f), .o_busy(busy_f), .o_err(err_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Scoreboards: grants popped on o_driveNext, expected free pulse queued from the expected channel.
  always @(negedge clk) begin
    if (!rst) begin
      if (dn_r) begin
        if (q_r.size() == 0) check("r_unexpected_drive", {29'd0, chan_r}, 32'hff);
        else begin
          e_r = q_r.pop_front();
          check("r_chan", {29'd0, chan_r}, {29'd0, e_r[7:5]});
          check("r_data", {27'd0, odata_r}, {27'd0, e_r[4:0]});
          fq_r.push_back(5'b00001 << e_r[7:5]);
        end
      end
      if (free_r != 5'd0) begin
        if (fq_r.size() == 0) check("r_unexpected_free", {27'd0, free_r}, 32'd0);
        else check("r_free", {27'd0, free_r}, {27'd0, fq_r.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dn_f) begin
        if (q_f.size() == 0) check("f_unexpected_drive", {29'd0, chan_f}, 32'hff);
        else begin
          e_f = q_f.pop_front();
          check("f_chan", {29'd0, chan_f}, {29'd0, e_f[7:5]});
          check("f_data", {27'd0, odata_f}, {27'd0, e_f[4:0]});
          fq_f.push_back(5'b00001 << e_f[7:5]);
        end
      end
      if (free_f != 5'd0) begin
        if (fq_f.size() == 0) check("f_unexpected_free", {27'd0, free_f}, 32'd0);
        else check("f_free", {27'd0, free_f}, {27'd0, fq_f.pop_front()});
      end
    end
  end

  // Downstream responders: return freeNext a few cycles after each driveNext.
  initial begin
    fn_auto_r = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_r && dn_r && !rst) begin
        repeat (2) @(negedge clk);
        fn_auto_r = 1'b1;
        @(negedge clk);
        fn_auto_r = 1'b0;
      end
    end
  end

  initial begin
    fn_auto_f = 1'b0;
    forever begin
      @(negedge clk);
      if (dn_f && !rst) begin
        repeat (2) @(negedge clk);
        fn_auto_f = 1'b1;
        @(negedge clk);
        fn_auto_f = 1'b0;
      end
    end
  end

  task automatic drv_r(input logic [4:0] mask, input logic [24:0] d);
    drive_r = mask;
    data_r  = d;
    @(negedge clk);
    drive_r = 5'd0;
  endtask

  task automatic drv_f(input logic [4:0] mask, input logic [24:0] d);
    drive_f = mask;
    data_f  = d;
    @(negedge clk);
    drive_f = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q_r.delete(); fq_r.delete(); q_f.delete(); fq_f.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle_r();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q_r.size() != 0 || fq_r.size() != 0 || busy_r) && n < 300);
    check("r_drained", q_r.size() + fq_r.size(), 0);
    check("r_idle_busy", {31'd0, busy_r}, 32'd0);
  endtask

  task automatic wait_idle_f();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q_f.size() != 0 || fq_f.size() != 0 || busy_f) && n < 300);
    check("f_drained", q_f.size() + fq_f.size(), 0);
    check("f_idle_busy", {31'd0, busy_f}, 32'd0);
  endtask

  task automatic wait_free4_f();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!free_f[4] && n < 300);
    check("f_ch4_freed", {31'd0, free_f[4]}, 32'd1);
  endtask

  initial begin
    int n;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; auto_r = 1'b1; fn_man_r = 1'b0;
    drive_r = 5'd0; data_r = 25'd0; drive_f = 5'd0; data_f = 25'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_drive", {31'd0, dn_r}, 32'd0);
    check("rst_free", {27'd0, free_r}, 32'd0);
    check("rst_data", {27'd0, odata_r}, 32'd0);
    check("rst_chan", {29'd0, chan_r}, 32'd0);
    check("rst_busy", {31'd0, busy_r}, 32'd0);
    check("rst_err", {31'd0, err_r}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single token on ch2 with latency checks
    drive_r = 5'b00100; data_r = {5'd0, 5'd0, 5'h15, 5'd0, 5'd0};
    q_r.push_back({3'd2, 5'h15});
    @(negedge clk);
    drive_r = 5'd0;
    check("lat_drive_early", {31'd0, dn_r}, 32'd0);
    @(negedge clk);
    check("lat_drive", {31'd0, dn_r}, 32'd1);
    check("lat_busy", {31'd0, busy_r}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (free_r == 5'd0 && n < 50);
    check("single_free", {27'd0, free_r}, 32'b00100);
    check("single_busy_fall", {31'd0, busy_r}, 32'd0);
    @(negedge clk);
    check("single_free_pulse", {27'd0, free_r}, 32'd0);
    wait_idle_r();

    // Round-robin over all five, then wrap
    do_reset();
    drv_r(5'b11111, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1});
    for (int k = 0; k < 5; k++) q_r.push_back({3'(k), 5'(k + 1)});
    wait_idle_r();
    drv_r(5'b01001, {5'd0, 5'h13, 5'd0, 5'd0, 5'h11});
    q_r.push_back({3'd0, 5'h11});
    q_r.push_back({3'd3, 5'h13});
    wait_idle_r();

    // Data latched on drive; later input changes ignored
    drv_r(5'b00001, {5'd0, 5'd0, 5'd0, 5'd0, 5'h07});
    q_r.push_back({3'd0, 5'h07});
    drv_r(5'b00010, {5'd0, 5'd0, 5'd0, 5'h0A, 5'd0});
    q_r.push_back({3'd1, 5'h0A});
    data_r = {5'd0, 5'd0, 5'd0, 5'h1F, 5'd0};
    wait_idle_r();
    check("no_err_yet", {31'd0, err_r}, 32'd0);

    // Double drive on ch3: error, only one token
    drv_r(5'b01000, {5'd0, 5'h13, 5'd0, 5'd0, 5'd0});
    q_r.push_back({3'd3, 5'h13});
    drv_r(5'b01000, {5'd0, 5'h1C, 5'd0, 5'd0, 5'd0});
    wait_idle_r();
    check("double_drive_err", {31'd0, err_r}, 32'd1);

    // freeNext in IDLE
    do_reset();
    check("err_cleared", {31'd0, err_r}, 32'd0);
    fn_man_r = 1'b1;
    @(negedge clk);
    fn_man_r = 1'b0;
    check("idle_free_err", {31'd0, err_r}, 32'd1);
    check("idle_free_nopulse", {27'd0, free_r}, 32'd0);
    @(negedge clk);
    check("idle_free_nopulse2", {27'd0, free_r}, 32'd0);

    // Async reset mid-WAIT with three pending, rr_ptr moved off zero first
    drv_r(5'b00100, {5'd0, 5'd0, 5'h02, 5'd0, 5'd0});
    q_r.push_back({3'd2, 5'h02});
    wait_idle_r();
    auto_r = 1'b0;
    drv_r(5'b00111, {5'd0, 5'd0, 5'h1D, 5'h1E, 5'h1B});
    q_r.push_back({3'd0, 5'h1B});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q_r.size() != 0 && n < 50);
    check("pre_rst_busy", {31'd0, busy_r}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_data", {27'd0, odata_r}, 32'd0);
    check("arst_chan", {29'd0, chan_r}, 32'd0);
    check("arst_busy", {31'd0, busy_r}, 32'd0);
    check("arst_err", {31'd0, err_r}, 32'd0);
    check("arst_drive", {31'd0, dn_r}, 32'd0);
    @(negedge clk);
    q_r.delete(); fq_r.delete();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_nofree", {27'd0, free_r}, 32'd0);
    check("post_rst_idle", {31'd0, busy_r}, 32'd0);
    auto_r = 1'b1;
    drv_r(5'b01010, {5'd0, 5'h0D, 5'd0, 5'h0B, 5'd0});
    q_r.push_back({3'd1, 5'h0B});
    q_r.push_back({3'd3, 5'h0D});
    wait_idle_r();

    // Fixed priority: ch4 re-drives right after its free, lower indices first
    drv_f(5'b11111, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1});
    for (int k = 0; k < 5; k++) q_f.push_back({3'(k), 5'(k + 1)});
    wait_free4_f();
    drv_f(5'b10000, {5'h18, 5'd0, 5'd0, 5'd0, 5'd0});
    q_f.push_back({3'd4, 5'h18});
    wait_idle_f();
    drv_f(5'b00010, {5'd0, 5'd0, 5'd0, 5'h09, 5'd0});
    q_f.push_back({3'd1, 5'h09});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q_f.size() != 0 && n < 50);
    drv_f(5'b10101, {5'h1A, 5'd0, 5'h0C, 5'd0, 5'h0E});
    q_f.push_back({3'd0, 5'h0E});
    q_f.push_back({3'd2, 5'h0C});
    q_f.push_back({3'd4, 5'h1A});
    wait_free4_f();
    drv_f(5'b11000, {5'h04, 5'h03, 5'd0, 5'd0, 5'd0});
    q_f.push_back({3'd3, 5'h03});
    q_f.push_back({3'd4, 5'h04});
    wait_idle_f();
    check("f_no_err", {31'd0, err_f}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
